// File: rtl/fb_port_arbiter.sv
// ----------------------------------------------------------------------------
// fb_port_arbiter
//
// Purpose
//   Shares one single-port frame-buffer BRAM between the two camera write
//   streams (cam0, cam1) and the VGA pixel read stream. At most one access is
//   granted per cycle:
//     - VGA read always wins.
//     - The cameras share what is left round-robin.
//   cam1 addresses are offset by CAM1_BASE so each camera has its own half of
//   a split buffer. Read data comes back exactly two cycles after the request:
//   one cycle for the BRAM and one for the output register.
//   Each camera also has a debug counter of starve events. A starve event is
//   STARVE_MAX cycles spent waiting with valid high.
//
// Ports
//   clk               single clock for all logic and the BRAM port
//   rst               synchronous, active-high reset
//   cam0_valid        cam0 write request
//   cam0_addr         cam0 write address, frame-relative
//   cam0_data         cam0 pixel
//   cam0_ready        high in the cycle cam0 is granted (write taken)
//   cam1_*            same as cam0; address is offset by CAM1_BASE
//   vga_rd_req        VGA read request
//   vga_rd_addr       VGA read address, absolute
//   vga_rd_data       read data, held until the next valid read
//   vga_rd_valid      one-cycle pulse, two cycles after the granted request
//   mem_en/mem_we     BRAM enable / write enable
//   mem_addr          BRAM address, holds last value when idle
//   mem_wdata         BRAM write data, holds last value when idle
//   mem_rdata         BRAM read data (registered, 1-cycle latency)
//   starve_cnt0/1     saturating starve-event counters
// ----------------------------------------------------------------------------
module fb_port_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 12,
  parameter int CAM1_BASE  = 307200,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cam0_valid,
  input  logic [ADDR_W-1:0] cam0_addr,
  input  logic [DATA_W-1:0] cam0_data,
  output logic              cam0_ready,

  input  logic              cam1_valid,
  input  logic [ADDR_W-1:0] cam1_addr,
  input  logic [DATA_W-1:0] cam1_data,
  output logic              cam1_ready,

  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_addr,
  output logic [DATA_W-1:0] vga_rd_data,
  output logic              vga_rd_valid,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [7:0]        starve_cnt0,
  output logic [7:0]        starve_cnt1
);

  // Round-robin pointer between the cameras
  //   state   | meaning
  //   RR_CAM0 | cam0 wins if both cameras request in the same cycle
  //   RR_CAM1 | cam1 wins if both cameras request in the same cycle
  typedef enum logic {
    RR_CAM0 = 1'b0,
    RR_CAM1 = 1'b1
  } rr_e;

  localparam int                WAIT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_TC  = WAIT_W'(STARVE_MAX - 1);
  localparam logic [ADDR_W-1:0] CAM1_OFS = ADDR_W'(CAM1_BASE);

  rr_e               rr_q, rr_d;
  logic              gnt_vga, gnt_cam0, gnt_cam1;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [DATA_W-1:0] wdata_hold_q;
  logic              rd_pend_q;

  logic [1:0]        cam_valid, cam_gnt;
  logic [WAIT_W-1:0] wait_q   [2];
  logic [7:0]        starve_q [2];

  // --------------------------------------------------------------------------
  // Grant and next-pointer logic. Reset blocks all grants, so nothing is
  // written while rst is high.
  // --------------------------------------------------------------------------
  always_comb begin
    gnt_vga  = 1'b0;
    gnt_cam0 = 1'b0;
    gnt_cam1 = 1'b0;
    rr_d     = rr_q;

    if (!rst) begin
      if (vga_rd_req) begin
        gnt_vga = 1'b1;
      end else if (cam0_valid && cam1_valid) begin
        if (rr_q == RR_CAM0) gnt_cam0 = 1'b1;
        else                 gnt_cam1 = 1'b1;
      end else if (cam0_valid) begin
        gnt_cam0 = 1'b1;
      end else if (cam1_valid) begin
        gnt_cam1 = 1'b1;
      end
    end

    // The pointer only moves after a camera grant. After a grant it hands
    // priority to the camera that was not just served.
    if (gnt_cam0) rr_d = RR_CAM1;
    if (gnt_cam1) rr_d = RR_CAM0;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= RR_CAM0;
    else     rr_q <= rr_d;
  end

  assign cam0_ready = gnt_cam0;
  assign cam1_ready = gnt_cam1;

  // --------------------------------------------------------------------------
  // Memory port. The port is driven combinationally so that the BRAM samples
  // the request in the grant cycle. When idle, the port shows the hold
  // registers. Because those registers copy the port every cycle, address and
  // data stay at their last values until the next grant.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_en    = gnt_vga | gnt_cam0 | gnt_cam1;
    mem_we    = gnt_cam0 | gnt_cam1;
    mem_addr  = addr_hold_q;
    mem_wdata = wdata_hold_q;

    if (gnt_vga) begin
      mem_addr  = vga_rd_addr;
    end else if (gnt_cam0) begin
      mem_addr  = cam0_addr;
      mem_wdata = cam0_data;
    end else if (gnt_cam1) begin
      // Wraps modulo 2**ADDR_W by design; no bounds check is made.
      mem_addr  = cam1_addr + CAM1_OFS;
      mem_wdata = cam1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      addr_hold_q  <= mem_addr;
      wdata_hold_q <= mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read return. rd_pend_q tracks which BRAM output cycle carries VGA data.
  // The output register then adds the second cycle of latency. Reset clears
  // rd_pend_q, so a read that is in flight during reset is dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q    <= 1'b0;
      vga_rd_valid <= 1'b0;
      vga_rd_data  <= '0;
    end else begin
      rd_pend_q    <= gnt_vga;
      vga_rd_valid <= rd_pend_q;
      if (rd_pend_q) vga_rd_data <= mem_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // Starvation monitor, one instance per camera. These counters are for
  // debug only and never change the grant.
  // --------------------------------------------------------------------------
  assign cam_valid = {cam1_valid, cam0_valid};
  assign cam_gnt   = {gnt_cam1, gnt_cam0};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wait_q[i]   <= '0;
        starve_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!cam_valid[i] || cam_gnt[i]) begin
          wait_q[i] <= '0;
        end else if (wait_q[i] == WAIT_TC) begin
          // This cycle is the STARVE_MAX-th consecutive wait.
          wait_q[i] <= '0;
          if (starve_q[i] != 8'hFF) starve_q[i] <= starve_q[i] + 8'd1;
        end else begin
          wait_q[i] <= wait_q[i] + 1'b1;
        end
      end
    end
  end

  assign starve_cnt0 = starve_q[0];
  assign starve_cnt1 = starve_q[1];

endmodule
